// File: rtl/sim_state_tracer.sv
`default_nettype none
// ============================================================================
//  Module   : sim_state_tracer
//  Purpose  : Trace stage for the cycle-level simulator core. Samples the
//             core's state / current_cycle each clock and records an entry on
//             every state change or cycle-counter wrap. Entries are queued in a
//             first-word-fall-through FIFO drained over a valid/ready port.
//             Events lost to a full FIFO are flagged (overflow) and counted.
//  Ports    : clk, reset_n (sync, active-low), enable, clear (sync flush),
//             state, current_cycle            -- sampled simulator outputs
//             out_valid/out_ready             -- head-entry handshake
//             out_state/out_cycle/out_wrap    -- head entry fields
//             count                           -- FIFO occupancy 0..DEPTH
//             overflow, dropped               -- loss reporting
//  Revision : 1.0 - initial release
// ============================================================================
module sim_state_tracer #(
    parameter int MAX_CYCLE_WIDTH = 5,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [1:0]                 state,
    input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_state,
    output logic [MAX_CYCLE_WIDTH-1:0] out_cycle,
    output logic                       out_wrap,
    output logic [ADDR_WIDTH:0]        count,
    output logic                       overflow,
    output logic [7:0]                 dropped
);

    localparam int                  c_entry_w    = MAX_CYCLE_WIDTH + 3;
    localparam logic [ADDR_WIDTH:0] c_full_count = (ADDR_WIDTH+1)'(DEPTH);

    // Entry layout: {wrap, state[1:0], cycle}
    logic [c_entry_w-1:0]       mem_q [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0]      wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]      rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]        count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [7:0]                 dropped_q, dropped_d;
    logic                       armed_q, armed_d;
    logic [1:0]                 prev_state_q, prev_state_d;
    logic [MAX_CYCLE_WIDTH-1:0] prev_cycle_q, prev_cycle_d;

    logic                       w_change;
    logic                       w_wrap;
    logic                       w_event;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_drop;
    logic [c_entry_w-1:0]       w_entry;
    logic [c_entry_w-1:0]       w_head;

    // Change/wrap are only meaningful once a previous sample exists; an
    // unarmed enabled cycle always produces a baseline entry with wrap=0.
    assign w_change = armed_q && (state != prev_state_q);
    assign w_wrap   = armed_q && (current_cycle < prev_cycle_q);
    assign w_event  = enable && (!armed_q || w_change || w_wrap);
    assign w_entry  = {w_wrap, state, current_cycle};

    // Clear suppresses every push/pop in its cycle.
    assign w_full   = (count_q == c_full_count);
    assign w_pop    = !clear && out_valid && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign w_push   = !clear && w_event && (!w_full || w_pop);
    assign w_drop   = !clear && w_event && w_full && !w_pop;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        dropped_d    = dropped_q;
        armed_d      = armed_q;
        prev_state_d = prev_state_q;
        prev_cycle_d = prev_cycle_q;

        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            dropped_d  = '0;
            armed_d    = 1'b0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (w_drop) begin
                overflow_d = 1'b1;
                if (dropped_q != 8'hFF) begin
                    dropped_d = dropped_q + 8'd1;
                end
            end
            // Tracking follows the inputs on every enabled cycle, regardless
            // of whether the event was stored or dropped.
            if (enable) begin
                armed_d      = 1'b1;
                prev_state_d = state;
                prev_cycle_d = current_cycle;
            end else begin
                armed_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= '0;
            armed_q      <= 1'b0;
            prev_state_q <= '0;
            prev_cycle_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            armed_q      <= armed_d;
            prev_state_q <= prev_state_d;
            prev_cycle_q <= prev_cycle_d;
        end
    end

    // Storage needs no reset: it is only visible through count != 0.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            mem_q[wptr_q] <= w_entry;
        end
    end

    assign out_valid = (count_q != '0);
    assign w_head    = out_valid ? mem_q[rptr_q] : '0;
    assign out_wrap  = w_head[c_entry_w-1];
    assign out_state = w_head[MAX_CYCLE_WIDTH +: 2];
    assign out_cycle = w_head[MAX_CYCLE_WIDTH-1:0];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_state_tracer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_state_tracer
//  Purpose  : Self-checking bench for sim_state_tracer. Directed scenarios
//             plus randomized traffic checked against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_state_tracer;

    localparam int MCW   = 5;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic           clk;
    logic           reset_n;
    logic           enable;
    logic           clear;
    logic [1:0]     state;
    logic [MCW-1:0] current_cycle;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_state;
    logic [MCW-1:0] out_cycle;
    logic           out_wrap;
    logic [AW:0]    count;
    logic           overflow;
    logic [7:0]     dropped;

    int checks = 0;
    int errors = 0;

    // {valid, wrap, state, cycle}
    logic [8:0] head_w;
    assign head_w = {out_valid, out_wrap, out_state, out_cycle};

    sim_state_tracer #(.MAX_CYCLE_WIDTH(MCW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .state(state), .current_cycle(current_cycle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_cycle(out_cycle), .out_wrap(out_wrap),
        .count(count), .overflow(overflow), .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]     mq [$];     // entries {wrap, state, cycle}
    bit             m_armed;
    logic [1:0]     m_ps;
    logic [MCW-1:0] m_pc;
    bit             m_ovf;
    int             m_drp;

    task automatic model_step();
        int  sz0;
        bit  ev, w, popd;
        if (!reset_n) begin
            mq.delete(); m_ovf = 0; m_drp = 0; m_armed = 0; m_ps = 0; m_pc = 0;
        end else if (clear) begin
            mq.delete(); m_ovf = 0; m_drp = 0; m_armed = 0;
        end else begin
            ev = 0; w = 0;
            if (enable) begin
                if (!m_armed) ev = 1;
                else begin
                    w  = (int'(current_cycle) < int'(m_pc));
                    ev = (state != m_ps) || w;
                end
            end
            sz0  = mq.size();
            popd = (sz0 > 0) && out_ready;
            if (popd) void'(mq.pop_front());
            if (ev) begin
                if (sz0 < DEPTH || popd) mq.push_back({w, state, current_cycle});
                else begin
                    m_ovf = 1;
                    if (m_drp < 255) m_drp++;
                end
            end
            if (enable) begin
                m_armed = 1; m_ps = state; m_pc = current_cycle;
            end else m_armed = 0;
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit en, input logic [1:0] s, input int c, input bit rdy);
        enable = en; state = s; current_cycle = MCW'(c); out_ready = rdy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 0; clear = 0; set_in(1, 2'd2, 7, 1);
        do_cycle(); do_cycle();
        checks++; if (head_w !== 9'd0) begin errors++; $display("FAIL reset_head got=%h exp=%h", head_w, 9'd0); end
        checks++; if ({count, overflow, dropped} !== 13'd0) begin errors++;
            $display("FAIL reset_stats got count=%0d ovf=%0d drp=%0d exp 0/0/0", count, overflow, dropped); end
    endtask

    task automatic test_baseline();
        reset_n = 1; set_in(1, 2'd0, 3, 0);
        do_cycle();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL baseline_count got=%0d exp=1", count); end
        checks++; if (head_w !== {1'b1, 1'b0, 2'd0, 5'd3}) begin errors++;
            $display("FAIL baseline_head got=%h exp=%h", head_w, {1'b1, 1'b0, 2'd0, 5'd3}); end
        repeat (3) do_cycle();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL baseline_hold_count got=%0d exp=1", count); end
    endtask

    task automatic test_drain_order();
        logic [8:0] exp_tbl [3];
        exp_tbl[0] = {1'b1, 1'b0, 2'd0, 5'd3};
        exp_tbl[1] = {1'b1, 1'b0, 2'd1, 5'd4};
        exp_tbl[2] = {1'b1, 1'b0, 2'd2, 5'd5};
        set_in(1, 2'd1, 4, 0); do_cycle();
        set_in(1, 2'd2, 5, 0); do_cycle();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL drain_fill_count got=%0d exp=3", count); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (head_w !== exp_tbl[i]) begin errors++;
                $display("FAIL drain_head%0d got=%h exp=%h", i, head_w, exp_tbl[i]); end
            do_cycle();
        end
        checks++; if ({out_valid, count} !== 5'd0) begin errors++;
            $display("FAIL drain_empty got valid=%0d count=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_wrap();
        set_in(1, 2'd1, 31, 0); do_cycle();
        set_in(1, 2'd1, 0, 0);  do_cycle();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", count); end
        out_ready = 1; do_cycle();
        checks++; if (head_w !== {1'b1, 1'b1, 2'd1, 5'd0}) begin errors++;
            $display("FAIL wrap_head got=%h exp=%h", head_w, {1'b1, 1'b1, 2'd1, 5'd0}); end
        set_in(1, 2'd1, 31, 1); do_cycle();
        set_in(1, 2'd2, 0, 0);  do_cycle();
        checks++; if ({count, head_w} !== {4'd1, 1'b1, 1'b1, 2'd2, 5'd0}) begin errors++;
            $display("FAIL wrap_change got count=%0d head=%h exp count=1 head=%h", count, head_w, {1'b1, 1'b1, 2'd2, 5'd0}); end
        set_in(1, 2'd2, 1, 1); do_cycle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", count); end
    endtask

    task automatic fill_changes(input int n);
        reset_n = 0; set_in(1, 2'd0, 0, 0); do_cycle();
        reset_n = 1; do_cycle();   // baseline
        for (int i = 1; i <= n; i++) begin
            set_in(1, 2'(i % 2), i, 0); do_cycle();
        end
    endtask

    task automatic test_overflow();
        fill_changes(10);
        checks++; if ({count, overflow, dropped} !== {4'd8, 1'b1, 8'd3}) begin errors++;
            $display("FAIL ovf_stats got count=%0d ovf=%0d drp=%0d exp 8/1/3", count, overflow, dropped); end
        set_in(1, 2'd3, 11, 1); do_cycle();   // event plus pop while full
        checks++; if ({count, overflow, dropped} !== {4'd8, 1'b1, 8'd3}) begin errors++;
            $display("FAIL full_pushpop got count=%0d ovf=%0d drp=%0d exp 8/1/3", count, overflow, dropped); end
    endtask

    task automatic test_clear();
        fill_changes(9);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2'd1, 12 + i, 1); do_cycle();
        end
        out_ready = 0;
        checks++; if ({count, dropped} !== {4'd5, 8'd2}) begin errors++;
            $display("FAIL clear_setup got count=%0d drp=%0d exp 5/2", count, dropped); end
        clear = 1; set_in(1, 2'd2, 16, 1); do_cycle();
        clear = 0;
        checks++; if ({count, overflow, dropped, out_valid} !== 14'd0) begin errors++;
            $display("FAIL clear_stats got count=%0d ovf=%0d drp=%0d exp 0/0/0", count, overflow, dropped); end
        set_in(1, 2'd3, 20, 0); do_cycle();
        checks++; if ({count, head_w} !== {4'd1, 1'b1, 1'b0, 2'd3, 5'd20}) begin errors++;
            $display("FAIL clear_baseline got count=%0d head=%h exp count=1 head=%h", count, head_w, {1'b1, 1'b0, 2'd3, 5'd20}); end
    endtask

    task automatic test_enable_gap();
        set_in(1, 2'd3, 21, 1); do_cycle();
        set_in(1, 2'd3, 22, 1); do_cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 2'(i), 23 + i, 0); do_cycle();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL disabled_count got=%0d exp=0", count); end
        set_in(1, 2'd1, 9, 0); do_cycle();
        checks++; if ({count, head_w} !== {4'd1, 1'b1, 1'b0, 2'd1, 5'd9}) begin errors++;
            $display("FAIL reenable_baseline got count=%0d head=%h exp count=1 head=%h", count, head_w, {1'b1, 1'b0, 2'd1, 5'd9}); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2'(i), 10 + i, 0); do_cycle();
        end
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL midreset_setup got=%0d exp=4", count); end
        out_ready = 1; reset_n = 0; do_cycle();
        checks++; if ({head_w, count, overflow, dropped} !== 22'd0) begin errors++;
            $display("FAIL midreset got head=%h count=%0d ovf=%0d drp=%0d exp all 0", head_w, count, overflow, dropped); end
        reset_n = 1;
    endtask

    task automatic test_saturate();
        fill_changes(270);
        checks++; if ({overflow, dropped} !== {1'b1, 8'd255}) begin errors++;
            $display("FAIL saturate got ovf=%0d drp=%0d exp 1/255", overflow, dropped); end
    endtask

    task automatic test_random();
        logic [8:0] exp_head;
        int         cyc_v;
        cyc_v = 0;
        reset_n = 0; clear = 0; do_cycle(); reset_n = 1;
        for (int i = 0; i < 2500; i++) begin
            cyc_v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : (cyc_v + 1) % 32;
            if ($urandom_range(0, 2) == 0) state = 2'($urandom_range(0, 3));
            current_cycle = MCW'(cyc_v);
            enable    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            reset_n   = ($urandom_range(0, 199) != 0);
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            do_cycle();
            exp_head = (mq.size() != 0) ? {1'b1, mq[0]} : 9'd0;
            checks++; if (head_w !== exp_head) begin errors++;
                $display("FAIL rand_head i=%0d got=%h exp=%h", i, head_w, exp_head); end
            checks++; if (count !== (AW+1)'(mq.size())) begin errors++;
                $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
            checks++; if ({overflow, dropped} !== {m_ovf, 8'(m_drp)}) begin errors++;
                $display("FAIL rand_loss i=%0d got ovf=%0d drp=%0d exp ovf=%0d drp=%0d", i, overflow, dropped, m_ovf, m_drp); end
        end
        clear = 0; reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_drain_order();
        test_wrap();
        test_overflow();
        test_clear();
        test_enable_gap();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
